// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the mul_acc block-sum accumulator.
// The MUL_ACC_SIGNED_EN macro selects two's-complement products and signed overflow detection.
package mul_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int PW_DEF    = 64;
    localparam int GUARD_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Overflow of one accumulate step, judged from the operand/result MSBs and the raw carry.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic carry
    );
        logic s_ovf;
        logic u_ovf;
        s_ovf = (a_msb == b_msb) && (sum_msb != a_msb);
        u_ovf = carry;
`ifdef MUL_ACC_SIGNED_EN
        return s_ovf;
`else
        return u_ovf;
`endif
    endfunction

endpackage

// File: rtl/mul_acc.sv
// Sums a programmable-length block of products into a guarded accumulator and hands the result
// off over valid/ready. MUL_ACC_SIGNED_EN switches to sign-extended products and signed overflow.
module mul_acc
    import mul_acc_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [CNT_W-1:0]    len,
    input  logic                prod_valid,
    input  logic [PW-1:0]       prod_data,
    output logic                prod_ready,
    output logic                acc_valid,
    output logic [PW+GUARD-1:0] acc_data,
    input  logic                acc_ready,
    output logic                acc_ovf,
    output logic                busy
);

    localparam int AW = PW + GUARD;

    state_e           state_q;
    logic [AW-1:0]    acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             acc_valid_q;

    logic [AW-1:0]    ext_d;
    logic [AW:0]      sum_d;
    logic             step_ovf_d;
    logic [CNT_W-1:0] len_eff_d;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        ext_d = '0;
`ifdef MUL_ACC_SIGNED_EN
        ext_d = {{GUARD{prod_data[PW-1]}}, prod_data};
`else
        ext_d = {{GUARD{1'b0}}, prod_data};
`endif
        sum_d      = {1'b0, acc_q} + {1'b0, ext_d};
        step_ovf_d = ovf_calc(acc_q[AW-1], ext_d[AW-1], sum_d[AW-1], sum_d[AW]);
        len_eff_d  = (len == '0) ? CNT_W'(1) : len;
        cnt_d      = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (prod_valid) begin
                        len_q <= len_eff_d;
                        acc_q <= ext_d;
                        ovf_q <= 1'b0;
                        cnt_q <= CNT_W'(1);
                        if (len_eff_d == CNT_W'(1)) begin
                            state_q     <= OUT;
                            acc_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (prod_valid) begin
                        acc_q <= sum_d[AW-1:0];
                        ovf_q <= ovf_q | step_ovf_d;
                        cnt_q <= cnt_d;
                        // cnt_d counts the product being accepted now.
                        if (cnt_d == len_q) begin
                            state_q     <= OUT;
                            acc_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (acc_ready) begin
                        state_q     <= IDLE;
                        acc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = (state_q == IDLE) || (state_q == ACC);
    assign acc_valid  = acc_valid_q;
    assign acc_data   = acc_q;
    assign acc_ovf    = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: a default-width instance plus a GUARD=1 instance sharing stimulus.
module tb_mul_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        prod_valid = 1'b0;
    logic [63:0] prod_data = 64'd0;
    logic        acc_ready = 1'b0;

    logic        prod_ready, acc_valid, acc_ovf, busy;
    logic [71:0] acc_data;
    logic        g1_prod_ready, g1_acc_valid, g1_acc_ovf, g1_busy;
    logic [64:0] g1_acc_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_acc u_dut (
        .clk(clk), .rst(rst), .clr(clr), .len(len),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
        .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
        .acc_ovf(acc_ovf), .busy(busy)
    );

    mul_acc #(.GUARD(1)) u_dut_g1 (
        .clk(clk), .rst(rst), .clr(clr), .len(len),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(g1_prod_ready),
        .acc_valid(g1_acc_valid), .acc_data(g1_acc_data), .acc_ready(acc_ready),
        .acc_ovf(g1_acc_ovf), .busy(g1_busy)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v);
        prod_valid = 1'b1;
        prod_data  = v;
        step();
        prod_valid = 1'b0;
    endtask

    task automatic drain();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", acc_valid); end
        total++; if (acc_data !== 72'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", acc_data); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", acc_ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        step();
        total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", prod_ready); end
    endtask

    task automatic test_single();
        len = 8'd1;
        send(64'd2937);
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", acc_valid); end
        total++; if (acc_data !== 72'd2937) begin bad++; $display("FAIL single_data got=%0d exp=2937", acc_data); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", acc_ovf); end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%b exp=0", prod_ready); end
        drain();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b exp=0", acc_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_drain_busy got=%b exp=0", busy); end
        total++; if (acc_data !== 72'd2937) begin bad++; $display("FAIL single_hold_data got=%0d exp=2937", acc_data); end
    endtask

    task automatic test_block3();
        logic [63:0] vals [3];
        vals[0] = 64'd2937; vals[1] = 64'd100; vals[2] = 64'd1;
        len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            send(vals[i]);
            if (i < 2) begin
                total++; if (prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
                    bad++; $display("FAIL block3_mid%0d got ready=%b valid=%b exp ready=1 valid=0", i, prod_ready, acc_valid);
                end
            end
        end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL block3_ready got=%b exp=0", prod_ready); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL block3_valid got=%b exp=1", acc_valid); end
        total++; if (acc_data !== 72'd3038) begin bad++; $display("FAIL block3_data got=%0d exp=3038", acc_data); end
        drain();
        len = 8'd0;
        send(64'd5);
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL len0_valid got=%b exp=1", acc_valid); end
        total++; if (acc_data !== 72'd5) begin bad++; $display("FAIL len0_data got=%0d exp=5", acc_data); end
        drain();
    endtask

    task automatic test_backpressure();
        len = 8'd1;
        send(64'd42);
        prod_valid = 1'b1;
        prod_data  = 64'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (acc_valid !== 1'b1 || acc_data !== 72'd42 || prod_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got valid=%b data=%0d ready=%b exp 1/42/0", i, acc_valid, acc_data, prod_ready);
            end
        end
        drain();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%b exp=0", acc_valid); end
        total++; if (acc_data !== 72'd42) begin bad++; $display("FAIL bp_drain_data got=%0d exp=42", acc_data); end
        total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%b exp=1", prod_ready); end
        step();
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", acc_valid); end
        total++; if (acc_data !== 72'd99) begin bad++; $display("FAIL bp_next_data got=%0d exp=99", acc_data); end
        drain();
    endtask

    task automatic test_guard();
        len = 8'd3;
        for (int i = 0; i < 3; i++) send(64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (g1_acc_data !== 65'h0_FFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL guard1_data got=%0h exp=0fffffffffffffffd", g1_acc_data); end
        total++; if (g1_acc_ovf !== 1'b1) begin bad++; $display("FAIL guard1_ovf got=%b exp=1", g1_acc_ovf); end
        total++; if (g1_acc_valid !== 1'b1) begin bad++; $display("FAIL guard1_valid got=%b exp=1", g1_acc_valid); end
        total++; if (acc_data !== 72'h02_FFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL guard8_data got=%0h exp=2fffffffffffffffd", acc_data); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL guard8_ovf got=%b exp=0", acc_ovf); end
        drain();
        total++; if (g1_acc_ovf !== 1'b1) begin bad++; $display("FAIL guard1_ovf_idle got=%b exp=1", g1_acc_ovf); end
        len = 8'd1;
        send(64'd7);
        total++; if (g1_acc_ovf !== 1'b0) begin bad++; $display("FAIL guard1_next_ovf got=%b exp=0", g1_acc_ovf); end
        total++; if (g1_acc_data !== 65'd7) begin bad++; $display("FAIL guard1_next_data got=%0d exp=7", g1_acc_data); end
        drain();
    endtask

    task automatic test_abort(input bit use_clr);
        len = 8'd4;
        send(64'd10);
        send(64'd10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort%0d_busy_before got=%b exp=1", use_clr, busy); end
        if (use_clr) begin
            clr = 1'b1;
            prod_valid = 1'b1;
            prod_data  = 64'd77;
            step();
            clr = 1'b0;
            prod_valid = 1'b0;
        end else begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        total++; if (acc_valid !== 1'b0 || acc_ovf !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort%0d_flags got valid=%b ovf=%b busy=%b exp 0/0/0", use_clr, acc_valid, acc_ovf, busy);
        end
        total++; if (acc_data !== 72'd0) begin bad++; $display("FAIL abort%0d_data got=%0d exp=0", use_clr, acc_data); end
        total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL abort%0d_ready got=%b exp=1", use_clr, prod_ready); end
        len = 8'd2;
        send(64'd10);
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL abort%0d_mid_valid got=%b exp=0", use_clr, acc_valid); end
        send(64'd20);
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL abort%0d_new_valid got=%b exp=1", use_clr, acc_valid); end
        total++; if (acc_data !== 72'd30) begin bad++; $display("FAIL abort%0d_new_data got=%0d exp=30", use_clr, acc_data); end
        drain();
    endtask

    task automatic test_gap();
        len = 8'd4;
        send(64'd1);
        send(64'd2);
        len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (busy !== 1'b1 || acc_valid !== 1'b0) begin
                bad++; $display("FAIL gap_idle%0d got busy=%b valid=%b exp 1/0", i, busy, acc_valid);
            end
        end
        send(64'd3);
        total++; if (busy !== 1'b1 || acc_valid !== 1'b0) begin bad++; $display("FAIL gap_third got busy=%b valid=%b exp 1/0", busy, acc_valid); end
        send(64'd4);
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b exp=1", acc_valid); end
        total++; if (acc_data !== 72'd10) begin bad++; $display("FAIL gap_data got=%0d exp=10", acc_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b exp=1", busy); end
        drain();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_block3();
        test_backpressure();
        test_guard();
        test_abort(1'b0);
        test_abort(1'b1);
        test_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_acc.md
Name: mul_acc

Overview:
- Downstream consumer of the 32x32 sequential multiplier's 64-bit product.
- Accepts a stream of unsigned products over a valid/ready handshake and sums a programmable number of them into a guarded accumulator.
- Presents each block sum on an output valid/ready handshake, with a sticky overflow flag.
- Sits between the multiplier and the result sink, forming the MAC datapath.

Parameters:
- PW, 64, product width; matches the multiplier output.
- GUARD, 8, accumulator guard bits; accumulator width is PW+GUARD.
- CNT_W, 8, width of the block-length field and the internal product counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous clear; abandons the current block.
- len  input  CNT_W  products per block; sampled on the first accepted product; 0 is treated as 1.
- prod_valid  input  1  product available.
- prod_data  input  PW  product value.
- prod_ready  output  1  block can accept a product this cycle.
- acc_valid  output  1  block sum available.
- acc_data  output  PW+GUARD  block sum.
- acc_ready  input  1  sink accepts the sum.
- acc_ovf  output  1  carry out of the accumulator occurred during this block.
- busy  output  1  a block is in progress or its result is pending (state != IDLE).

Behaviour:
- Reset values: state=IDLE, acc_data=0, acc_ovf=0, acc_valid=0, busy=0, internal count=0, latched length=0. prod_ready is 1 from the first cycle after rst deasserts.
- Priority: rst > clr > handshakes.
- clr returns the block to IDLE, zeroes acc_data/acc_ovf/count and drops acc_valid. A product presented in the same cycle as clr is not accepted.
- Transfer rule: a transfer happens when valid&ready are both high at a rising edge. prod_ready is a pure function of state, with no combinational path from prod_valid.
- FSM IDLE: prod_ready=1.
  - On transfer: latch L=max(len,1), acc<=zero-extended prod_data, ovf<=0, cnt<=1.
  - Next state is OUT if L==1, else ACC.
- FSM ACC: prod_ready=1.
  - On transfer: acc<=acc+prod_data (modulo 2^(PW+GUARD)), ovf<=ovf|carry, cnt<=cnt+1.
  - Go to OUT when this transfer is the L-th product.
  - With no transfer, the block holds indefinitely.
- FSM OUT: prod_ready=0, acc_valid=1, and acc_data/acc_ovf are stable.
  - On acc_ready, the next state is IDLE and acc_valid drops the following cycle.
  - There is no same-cycle bypass: a new product can be accepted no earlier than the cycle after the drain.
- Latency: acc_valid rises on the clock edge that accepts the last product, so it is visible in the cycle immediately after that transfer.
- Throughput: one product per cycle while in IDLE/ACC. The minimum block cost is L cycles plus 1 drain cycle.
- acc_data and acc_ovf keep their last value in IDLE until the next first-product load.
- Changing len mid-block has no effect.
- Arithmetic is unsigned by default. Wrap-around sets acc_ovf, which is sticky until the next block start, clr or rst.

Optional Feature:
- Macro: MUL_ACC_SIGNED_EN.
- Defined: prod_data is two's complement and is sign-extended to PW+GUARD. acc_ovf is signed overflow: both operand signs equal and the result sign differs.
- Undefined: unsigned zero-extension; acc_ovf is the carry out of the MSB.

Decomposition:
- Package mul_acc_pkg holds:
  - state enum (IDLE, ACC, OUT);
  - default width constants PW_DEF=64, GUARD_DEF=8, CNT_W_DEF=8;
  - a function computing overflow for the selected signedness.
- No sub-module: the adder, counter and FSM stay in one flat module.

Test Plan:
- len=1, product 64'd2937 (89*33) -> acc_valid one cycle after the transfer, acc_data=2937, acc_ovf=0; acc_ready=1 returns the block to IDLE.
- len=3, products 2937, 100, 1 on consecutive cycles -> prod_ready drops after the third, acc_data=3038; len=0 with a single product of 5 -> acc_data=5.
- Backpressure: hold acc_ready=0 for 5 cycles in OUT -> acc_valid and acc_data held stable, prod_ready=0, a pending prod_valid is not accepted; accepted the cycle after the drain.
- GUARD=1, len=3, three products of 64'hFFFF_FFFF_FFFF_FFFF:
  - acc_data=65'h0_FFFF_FFFF_FFFF_FFFD, acc_ovf=1;
  - the next block of len=1 with value 7 gives acc_ovf=0, acc_data=7.
- Abort mid-operation:
  - rst asserted after 2 of 4 products -> all outputs at reset values; a new block with len=2 of {10,20} gives 30.
  - Repeat using clr instead of rst -> same result.
- Gap tolerance: len=4 with prod_valid deasserted for 3 cycles between products 2 and 3 (values 1,2,3,4) -> acc_data=10, busy=1 throughout.
